// File: rtl/submaster_rd_arb_pkg.sv
// submaster_rd_arb_pkg: FSM state encoding and AXI constants shared by the submaster arbiters.
package submaster_rd_arb_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, ADDR, DATA, DONE} state_t;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    return oh[2] ? 2'd2 : {1'b0, oh[1] & ~oh[0]};
  endfunction
endpackage

// File: rtl/submaster_rd_arb_if.sv
// submaster_rd_arb_if: AXI read address and read data channels of the shared master port.
interface submaster_rd_arb_if #(parameter int ADDR_W = 32, parameter int DATA_W = 64);
  logic [ADDR_W-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input arready, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/submaster_rd_arb_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker; scans last+1, last+2, last+3 (mod 3).
module rr_pick3
  import submaster_rd_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] sel,
  output logic       valid
);
  logic [1:0] a, b, c;
  assign a = last == 2'd2 ? 2'd0 : last + 2'd1;
  assign b = a == 2'd2 ? 2'd0 : a + 2'd1;
  assign c = b == 2'd2 ? 2'd0 : b + 2'd1;
  assign sel = req[a] ? 3'b001 << a : req[b] ? 3'b001 << b : req[c] ? 3'b001 << c : 3'b000;
  assign valid = |req;
endmodule

// File: rtl/submaster_rd_arb.sv
// submaster_rd_arb: round-robin read arbiter giving three submasters turns on one AXI read port.
module submaster_rd_arb
  import submaster_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter logic [2:0] ARSIZE = 3'd3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_0,
  input  logic              start_1,
  input  logic              start_2,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [7:0]        len_0,
  input  logic [7:0]        len_1,
  input  logic [7:0]        len_2,
  output logic              grant_0,
  output logic              grant_1,
  output logic              grant_2,
  output logic              processing_submaster_0,
  output logic              processing_submaster_1,
  output logic              processing_submaster_2,
  output logic              rd_valid_0,
  output logic              rd_valid_1,
  output logic              rd_valid_2,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [1:0]        rd_resp,
  output logic              xfer_done_0,
  output logic              xfer_done_1,
  output logic              xfer_done_2,
  output logic              xfer_err,
  submaster_rd_arb_if.master axi
);
  state_t state;
  logic [1:0] sel, last;
  logic [ADDR_W-1:0] araddr;
  logic [7:0] arlen;
  logic [8:0] cnt;
  logic err, pick_v, bad, busy, beat;
  logic [2:0] pick;
  rr_pick3 u_pick (.req({start_2, start_1, start_0}), .last(last), .sel(pick), .valid(pick_v));
  // Overrun beats past arlen+1 are flagged as they arrive; a short or long burst is also caught at rlast.
  assign bad = axi.rresp == RESP_SLVERR || axi.rresp == RESP_DECERR ||
               (axi.rlast ? cnt != {1'b0, arlen} : cnt > {1'b0, arlen});
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sel <= 2'd0;
      last <= 2'd2;
      araddr <= '0;
      arlen <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_v) begin
          sel <= oh2idx(pick);
          state <= GRANT;
        end
        GRANT: begin
          araddr <= sel == 2'd0 ? addr_0 : sel == 2'd1 ? addr_1 : addr_2;
          arlen <= sel == 2'd0 ? len_0 : sel == 2'd1 ? len_1 : len_2;
          cnt <= '0;
          err <= 1'b0;
          last <= sel;
          state <= ADDR;
        end
        ADDR: if (axi.arready) state <= DATA;
        DATA: if (axi.rvalid) begin
          cnt <= cnt + 9'd1;
          if (bad) err <= 1'b1;
          if (axi.rlast) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign beat = state == DATA && axi.rvalid;
  assign grant_0 = state == GRANT && sel == 2'd0;
  assign grant_1 = state == GRANT && sel == 2'd1;
  assign grant_2 = state == GRANT && sel == 2'd2;
  assign processing_submaster_0 = busy && sel == 2'd0;
  assign processing_submaster_1 = busy && sel == 2'd1;
  assign processing_submaster_2 = busy && sel == 2'd2;
  assign rd_valid_0 = beat && sel == 2'd0;
  assign rd_valid_1 = beat && sel == 2'd1;
  assign rd_valid_2 = beat && sel == 2'd2;
  assign xfer_done_0 = state == DONE && sel == 2'd0;
  assign xfer_done_1 = state == DONE && sel == 2'd1;
  assign xfer_done_2 = state == DONE && sel == 2'd2;
  assign xfer_err = state == DONE && err;
  assign rd_data = axi.rdata;
  assign rd_last = axi.rlast;
  assign rd_resp = axi.rresp;
  assign axi.araddr = araddr;
  assign axi.arlen = arlen;
  assign axi.arsize = ARSIZE;
  assign axi.arburst = BURST_INCR;
  assign axi.arvalid = state == ADDR;
  assign axi.rready = state == DATA;
endmodule

// File: tb/tb_submaster_rd_arb.sv
// tb_submaster_rd_arb: randomized submaster traffic and AXI slave against a queue-based scoreboard.
module tb_submaster_rd_arb;
  typedef struct {int n; logic [31:0] a; logic [7:0] l;} ar_t;
  typedef struct {int n; logic [63:0] d; logic [1:0] r; logic l;} beat_t;
  typedef struct {int n; logic e; int nb;} done_t;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] start = 3'b000;
  logic [31:0] addr [3];
  logic [7:0] len [3];
  logic grant_0, grant_1, grant_2, proc_0, proc_1, proc_2, rv_0, rv_1, rv_2;
  logic done_0, done_1, done_2, xfer_err, rd_last;
  logic [63:0] rd_data;
  logic [1:0] rd_resp;
  logic [2:0] grant;
  assign grant = {grant_2, grant_1, grant_0};
  int vectors = 0, miscompares = 0, tmo_cnt = 0, grant_cnt = 0, done_cnt = 0, beats_seen = 0, m_owner = 0;
  bit plain = 1'b0;
  ar_t ar_q[$];
  beat_t beat_q[$];
  done_t done_q[$];
  submaster_rd_arb_if #(.ADDR_W(32), .DATA_W(64)) axi ();
  submaster_rd_arb dut (
    .clk(clk), .reset_n(reset_n),
    .start_0(start[0]), .start_1(start[1]), .start_2(start[2]),
    .addr_0(addr[0]), .addr_1(addr[1]), .addr_2(addr[2]),
    .len_0(len[0]), .len_1(len[1]), .len_2(len[2]),
    .grant_0(grant_0), .grant_1(grant_1), .grant_2(grant_2),
    .processing_submaster_0(proc_0), .processing_submaster_1(proc_1), .processing_submaster_2(proc_2),
    .rd_valid_0(rv_0), .rd_valid_1(rv_1), .rd_valid_2(rv_2),
    .rd_data(rd_data), .rd_last(rd_last), .rd_resp(rd_resp),
    .xfer_done_0(done_0), .xfer_done_1(done_1), .xfer_done_2(done_2),
    .xfer_err(xfer_err), .axi(axi)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // AXI slave: random AR stalls, random beat gaps, occasional error responses and short/long bursts.
  initial begin
    logic [7:0] alen;
    int nb, r;
    bit err, ok;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
    forever begin
      @(posedge clk); #1;
      axi.arready = 1'b0;
      if (!reset_n || !axi.arvalid) continue;
      if (!plain && $urandom_range(0, 3) != 0) continue;
      alen = axi.arlen;
      axi.arready = 1'b1;
      @(posedge clk); #1;
      axi.arready = 1'b0;
      if (!reset_n) continue;
      r = $urandom_range(0, 9);
      nb = plain ? alen + 1 : (r == 0 && alen > 0) ? $urandom_range(1, alen) :
           r == 1 ? alen + 1 + $urandom_range(1, 2) : alen + 1;
      err = 1'b0;
      ok = 1'b1;
      for (int b = 0; b < nb; b++) begin
        repeat (plain ? 0 : $urandom_range(0, 2)) begin
          axi.rvalid = 1'b0;
          @(posedge clk); #1;
        end
        if (!reset_n) begin ok = 1'b0; break; end
        axi.rvalid = 1'b1;
        axi.rdata = {$urandom, $urandom};
        axi.rresp = (!plain && $urandom_range(0, 15) == 0) ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00;
        axi.rlast = b == nb - 1;
        err |= axi.rresp[1];
        beat_q.push_back('{m_owner, axi.rdata, axi.rresp, axi.rlast});
        @(posedge clk); #1;
        if (!reset_n) begin ok = 1'b0; break; end
      end
      axi.rvalid = 1'b0;
      axi.rlast = 1'b0;
      if (ok) done_q.push_back('{m_owner, err || nb != alen + 1, nb});
    end
  end
  // Monitor: round-robin model, AR check, beat and done scoreboards.
  initial begin
    ar_t ea;
    beat_t eb;
    done_t ed;
    bit ar_active, m_busy;
    int tmo_seen, exp, m_last;
    logic [2:0] prev_req, g, pv, rv, dv;
    ar_active = 1'b0; m_busy = 1'b0; tmo_seen = 0; m_last = 2; prev_req = 3'b000;
    ea = '{0, 32'h0, 8'h0};
    forever begin
      @(negedge clk);
      g = grant;
      pv = {proc_2, proc_1, proc_0};
      rv = {rv_2, rv_1, rv_0};
      dv = {done_2, done_1, done_0};
      if (tmo_cnt != tmo_seen) begin
        chk("timeout", 64'(tmo_cnt), 64'(tmo_seen));
        tmo_seen = tmo_cnt;
      end
      if (!reset_n) begin
        chk("reset_outputs", {g, pv, rv, dv, xfer_err, axi.arvalid, axi.rready}, 0);
        chk("reset_ar", {axi.araddr, axi.arlen}, 0);
        ar_q.delete(); beat_q.delete(); done_q.delete();
        m_last = 2; m_busy = 1'b0; ar_active = 1'b0; done_cnt = grant_cnt;
      end else begin
        if (g != 3'b000) begin
          exp = 3;
          for (int i = 3; i >= 1; i--) if (prev_req[(m_last + i) % 3]) exp = (m_last + i) % 3;
          chk("grant", g, exp == 3 ? 3'b000 : 3'b001 << exp);
          chk("grant_while_busy", m_busy, 0);
          if (exp != 3) begin
            m_last = exp; m_owner = exp; m_busy = 1'b1; grant_cnt++; beats_seen = 0;
            ar_q.push_back('{exp, addr[exp], len[exp]});
          end
        end
        chk("processing", pv, m_busy ? 3'b001 << m_owner : 3'b000);
        if (axi.arvalid) begin
          if (!ar_active) begin
            chk("ar_pending", ar_q.size() != 0, 1);
            if (ar_q.size() != 0) ea = ar_q.pop_front();
            chk("arsize", axi.arsize, 3);
            chk("arburst", axi.arburst, 1);
          end
          chk("araddr", axi.araddr, ea.a);
          chk("arlen", axi.arlen, ea.l);
          ar_active = !axi.arready;
        end
        if (rv != 3'b000) begin
          chk("beat_pending", beat_q.size() != 0, 1);
          if (beat_q.size() != 0) begin
            eb = beat_q.pop_front();
            chk("rd_valid", rv, 3'b001 << eb.n);
            chk("rd_data", rd_data, eb.d);
            chk("rd_last", rd_last, eb.l);
            chk("rd_resp", rd_resp, eb.r);
          end
          beats_seen++;
        end
        if (dv != 3'b000) begin
          chk("done_pending", done_q.size() != 0, 1);
          if (done_q.size() != 0) begin
            ed = done_q.pop_front();
            chk("xfer_done", dv, 3'b001 << ed.n);
            chk("xfer_err", xfer_err, ed.e);
            chk("beat_count", 64'(beats_seen), 64'(ed.nb));
          end
          m_busy = 1'b0;
          done_cnt++;
        end else if (xfer_err) chk("xfer_err_without_done", xfer_err, 0);
      end
      prev_req = start;
    end
  end
  // Submaster stimulus: all three request from reset, then random traffic, then a mid-burst reset.
  initial begin
    int jobs, t;
    for (int n = 0; n < 3; n++) begin
      addr[n] = $urandom & 32'hFFFF_FFF8;
      len[n] = 8'($urandom_range(0, 7));
    end
    start = 3'b111;
    jobs = 3;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 20000 && (jobs < 60 || start != 3'b000); c++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 3; n++)
        if (start[n] && grant[n]) start[n] = 1'b0;
        else if (!start[n] && jobs < 60 && $urandom_range(0, 5) == 0) begin
          addr[n] = $urandom & 32'hFFFF_FFF8;
          len[n] = 8'($urandom_range(0, 3) == 0 ? $urandom_range(8, 20) : $urandom_range(0, 7));
          start[n] = 1'b1;
          jobs++;
        end
    end
    if (start != 3'b000) tmo_cnt++;
    for (t = 0; t < 500 && done_cnt != grant_cnt; t++) @(posedge clk);
    if (done_cnt != grant_cnt) tmo_cnt++;
    repeat (2) @(posedge clk);
    plain = 1'b1;
    @(posedge clk); #1;
    addr[1] = 32'h1000;
    len[1] = 8'd3;
    start[1] = 1'b1;
    for (t = 0; t < 50 && !grant[1]; t++) begin @(posedge clk); #1; end
    if (!grant[1]) tmo_cnt++;
    start[1] = 1'b0;
    @(posedge clk);
    for (t = 0; t < 50 && beats_seen < 2; t++) @(posedge clk);
    if (beats_seen < 2) tmo_cnt++;
    #2 reset_n = 1'b0;
    addr[0] = 32'h2000; len[0] = 8'd0;
    addr[2] = 32'h3000; len[2] = 8'd0;
    start[0] = 1'b1; start[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (t = 0; t < 100 && start != 3'b000; t++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 3; n++) if (start[n] && grant[n]) start[n] = 1'b0;
    end
    if (start != 3'b000) tmo_cnt++;
    for (t = 0; t < 100 && done_cnt != grant_cnt; t++) @(posedge clk);
    if (done_cnt != grant_cnt) tmo_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
